// File: rtl/tim_pkg.sv
// Shared definitions for the general-purpose timer.
//   cms_e          : counter alignment mode as carried on cms_i
//   DEF_CNT_WIDTH  : default counter / auto-reload width
//   DEF_PSC_WIDTH  : default prescaler width
package tim_pkg;

  typedef enum logic [1:0] {
    CMS_EDGE    = 2'b00,
    CMS_CENTER1 = 2'b01,
    CMS_CENTER2 = 2'b10,
    CMS_CENTER3 = 2'b11
  } cms_e;

  localparam int DEF_CNT_WIDTH = 16;
  localparam int DEF_PSC_WIDTH = 16;

endpackage

// File: rtl/tim_prescaler.sv
// Prescaler of the timer time base. Divides the kernel clock by psc_shadow+1.
// Ports:
//   clk_i   kernel clock
//   rst_i   synchronous active-high reset
//   en_i    count enable (counter enable of the timer)
//   clr_i   restart the division from zero (software update)
//   load_i  copy psc_i into the shadow register (update event)
//   psc_i   prescaler value, division = psc_i+1
//   tick_o  one-cycle tick; the counter advances on the edge where it is high
module tim_prescaler
  import tim_pkg::*;
#(
  parameter int PSC_WIDTH = DEF_PSC_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic                 load_i,
  input  logic [PSC_WIDTH-1:0] psc_i,
  output logic                 tick_o
);

  localparam logic [PSC_WIDTH-1:0] PSC_ONE = {{(PSC_WIDTH-1){1'b0}}, 1'b1};

  logic [PSC_WIDTH-1:0] psc_cnt;
  logic [PSC_WIDTH-1:0] psc_shadow;

  assign tick_o = en_i && (psc_cnt == psc_shadow);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      psc_cnt    <= '0;
      psc_shadow <= '0;
    end else begin
      if (load_i) begin
        psc_shadow <= psc_i;
      end
      if (clr_i) begin
        psc_cnt <= '0;
      end else if (en_i) begin
        psc_cnt <= tick_o ? '0 : psc_cnt + PSC_ONE;
      end
    end
  end

endmodule

// File: rtl/tim_time_base.sv
// Time base of the general-purpose timer: prescaler, counter, auto-reload
// shadow and update-event generation. Feeds every channel and the register block.
// Optional feature: define TIM_REPETITION_CNT_EN to add a repetition counter
// (ports rcr_i / rep_cnt_o) so that only every rcr_i+1 wraps become updates.
// Ports:
//   clk_i, rst_i          kernel clock, synchronous active-high reset
//   cen_i                 counter enable
//   dir_i                 0=up, 1=down (edge-aligned mode only)
//   cms_i                 00 edge-aligned, otherwise center-aligned
//   arpe_i                auto-reload preload enable
//   udis_i                update disable
//   urs_i                 only over/underflow requests the update flag
//   opm_i                 one-pulse mode
//   psc_i, arr_i          prescaler and auto-reload values
//   ug_i                  software update generation pulse
//   cnt_we_i, cnt_wdata_i counter write
//   rcr_i, rep_cnt_o      repetition value / count (optional)
//   cnt_o, dir_o          counter value, effective direction (1=down)
//   uev_o                 update event pulse, aligned with the wrapped counter value
//   uif_set_o             request to set the update interrupt flag
//   cen_clr_o             request to clear the counter enable (one-pulse mode)
// dir_o is the only piece of control state; it doubles as the observable
// up/down phase of center-aligned counting.
module tim_time_base
  import tim_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int PSC_WIDTH = DEF_PSC_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cen_i,
  input  logic                 dir_i,
  input  logic [1:0]           cms_i,
  input  logic                 arpe_i,
  input  logic                 udis_i,
  input  logic                 urs_i,
  input  logic                 opm_i,
  input  logic [PSC_WIDTH-1:0] psc_i,
  input  logic [CNT_WIDTH-1:0] arr_i,
  input  logic                 ug_i,
  input  logic                 cnt_we_i,
  input  logic [CNT_WIDTH-1:0] cnt_wdata_i,
`ifdef TIM_REPETITION_CNT_EN
  input  logic [7:0]           rcr_i,
  output logic [7:0]           rep_cnt_o,
`endif
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 dir_o,
  output logic                 uev_o,
  output logic                 uif_set_o,
  output logic                 cen_clr_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] cnt_q, cnt_nxt, arr_shadow;
  logic dir_q, dir_nxt;
  logic is_edge, tick_raw, tick, wrap, rep_zero, upd_wrap, uev_d;

  assign is_edge = (cms_i == CMS_EDGE);
  // Software update and counter writes both take the counter this cycle,
  // so a coincident prescaler tick must not count or wrap.
  assign tick    = tick_raw && !ug_i && !cnt_we_i;

  tim_prescaler #(
    .PSC_WIDTH(PSC_WIDTH)
  ) u_psc (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (cen_i),
    .clr_i (ug_i),
    .load_i(uev_d),
    .psc_i (psc_i),
    .tick_o(tick_raw)
  );

  always_comb begin
    cnt_nxt = cnt_q;
    dir_nxt = is_edge ? dir_i : dir_q;
    wrap    = 1'b0;
    if (ug_i) begin
      // Down-counting restarts from the incoming ARR, not the shadow.
      cnt_nxt = (is_edge && dir_i) ? arr_i : '0;
      if (!is_edge) dir_nxt = 1'b0;
    end else if (cnt_we_i) begin
      cnt_nxt = cnt_wdata_i;
    end else if (tick) begin
      if (is_edge) begin
        if (!dir_i) begin
          if (cnt_q == arr_shadow) begin
            cnt_nxt = '0;
            wrap    = 1'b1;
          end else begin
            cnt_nxt = cnt_q + CNT_ONE;
          end
        end else begin
          if (cnt_q == '0) begin
            cnt_nxt = arr_shadow;
            wrap    = 1'b1;
          end else begin
            cnt_nxt = cnt_q - CNT_ONE;
          end
        end
      end else if (arr_shadow == '0) begin
        cnt_nxt = '0;
        wrap    = 1'b1;
      end else if (!dir_q) begin
        // Center-aligned up phase: turning at the top is the overflow.
        // A counter already at/above the top (ARR lowered) turns at once.
        if (cnt_q >= arr_shadow) begin
          cnt_nxt = cnt_q - CNT_ONE;
          dir_nxt = 1'b1;
          wrap    = 1'b1;
        end else begin
          cnt_nxt = cnt_q + CNT_ONE;
          if (cnt_q + CNT_ONE == arr_shadow) begin
            dir_nxt = 1'b1;
            wrap    = 1'b1;
          end
        end
      end else begin
        // Center-aligned down phase: reaching zero is the underflow.
        if (cnt_q == '0) begin
          cnt_nxt = CNT_ONE;
          dir_nxt = 1'b0;
          wrap    = 1'b1;
        end else begin
          cnt_nxt = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            dir_nxt = 1'b0;
            wrap    = 1'b1;
          end
        end
      end
    end
  end

`ifdef TIM_REPETITION_CNT_EN
  logic [7:0] rep_q;

  assign rep_zero  = (rep_q == 8'd0);
  assign rep_cnt_o = rep_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rep_q <= 8'd0;
    end else if (ug_i) begin
      rep_q <= rcr_i;
    end else if (wrap) begin
      rep_q <= rep_zero ? rcr_i : rep_q - 8'd1;
    end
  end
`else
  assign rep_zero = 1'b1;
`endif

  assign upd_wrap = wrap && rep_zero;
  assign uev_d    = !udis_i && (ug_i || upd_wrap);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      dir_q      <= 1'b0;
      arr_shadow <= '0;
      uev_o      <= 1'b0;
      uif_set_o  <= 1'b0;
      cen_clr_o  <= 1'b0;
    end else begin
      cnt_q <= cnt_nxt;
      dir_q <= dir_nxt;
      if (!arpe_i || uev_d) begin
        arr_shadow <= arr_i;
      end
      uev_o     <= uev_d;
      uif_set_o <= !udis_i && (upd_wrap || (ug_i && !urs_i));
      // The counter wraps even with updates disabled, so one-pulse stop
      // follows the wrap itself.
      cen_clr_o <= opm_i && upd_wrap;
    end
  end

  assign cnt_o = cnt_q;
  assign dir_o = dir_q;

endmodule
